// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter between instruction fetch and data ports onto one 16-bit memory
// Each access holds the memory for LAT busy cycles; unaligned requests complete with an error and no access.
module mem_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [15:0]           i_rdata,
    output logic                  i_done,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic                  i_stall,
    output logic                  d_stall,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
    state_t state;
    logic [2:0] cnt;
    logic last_d, wr_q, i_done_q, d_done_q, i_err_q, d_err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0] wdata_q, i_rdata_q, d_rdata_q;
    logic grant_d, grant_i, fire, unaligned;
    // On a tie the data side wins unless it was the last one served
    assign grant_d = d_req && (!i_req || !last_d);
    assign grant_i = i_req && !grant_d;
    assign unaligned = addr_q[0];
    assign fire = state != IDLE && cnt == 3'd0;
    // Outputs are forced low during reset so the memory sees no command while it loads
    assign mem_en = !rst && fire && !unaligned;
    assign mem_wr = mem_en && wr_q;
    assign mem_addr = rst ? '0 : addr_q;
    assign mem_wdata = rst ? '0 : wdata_q;
    assign i_rdata = rst ? '0 : i_rdata_q;
    assign d_rdata = rst ? '0 : d_rdata_q;
    assign i_done = !rst && i_done_q;
    assign d_done = !rst && d_done_q;
    assign i_err = !rst && i_err_q;
    assign d_err = !rst && d_err_q;
    assign i_stall = i_req && !i_done;
    assign d_stall = d_req && !d_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 3'd0;
            last_d <= 1'b0;
            wr_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
            if (state == IDLE) begin
                if (grant_d || grant_i) begin
                    state <= grant_d ? BUSY_D : BUSY_I;
                    cnt <= CNT_INIT;
                    last_d <= grant_d;
                    addr_q <= grant_d ? d_addr : i_addr;
                    wr_q <= grant_d && d_wr;
                    wdata_q <= grant_d ? d_wdata : '0;
                end
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end else begin
                state <= IDLE;
                if (state == BUSY_I) begin
                    i_done_q <= 1'b1;
                    i_err_q <= unaligned;
                    i_rdata_q <= unaligned ? '0 : mem_rdata;
                end else begin
                    d_done_q <= 1'b1;
                    d_err_q <= unaligned;
                    d_rdata_q <= (unaligned || wr_q) ? '0 : mem_rdata;
                end
            end
        end
    end
endmodule
